// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD test-pattern generator: mode encodings,
// the eight-entry bar palette and the gradient pixel packing.
package lcd_pkg;

  typedef enum logic [2:0] {
    MODE_SPLIT    = 3'd0,
    MODE_SOLID    = 3'd1,
    MODE_BARS     = 3'd2,
    MODE_CHECKER  = 3'd3,
    MODE_GRADIENT = 3'd4,
    MODE_SCROLL   = 3'd5
  } mode_e;

  localparam logic [15:0] BAR_COLOR_0 = 16'hFFFF;
  localparam logic [15:0] BAR_COLOR_1 = 16'hFFE0;
  localparam logic [15:0] BAR_COLOR_2 = 16'h07FF;
  localparam logic [15:0] BAR_COLOR_3 = 16'h07E0;
  localparam logic [15:0] BAR_COLOR_4 = 16'hF81F;
  localparam logic [15:0] BAR_COLOR_5 = 16'hF800;
  localparam logic [15:0] BAR_COLOR_6 = 16'h001F;
  localparam logic [15:0] BAR_COLOR_7 = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_COLOR_0;
      3'd1:    c = BAR_COLOR_1;
      3'd2:    c = BAR_COLOR_2;
      3'd3:    c = BAR_COLOR_3;
      3'd4:    c = BAR_COLOR_4;
      3'd5:    c = BAR_COLOR_5;
      3'd6:    c = BAR_COLOR_6;
      default: c = BAR_COLOR_7;
    endcase
    return c;
  endfunction

  // Grey level g spread over RGB565; green's sixth bit repeats g's MSB.
  function automatic logic [15:0] grad_pixel(input logic [4:0] g);
    return {g, g, g[4], g};
  endfunction

endpackage

// File: rtl/lcd_bar_index.sv
// Colour-bar index from the x coordinate: counts how many of the seven bar
// boundaries x has reached, so no divider is needed.
module lcd_bar_index #(
  parameter int SCREEN_WIDTH = 320
) (
  input  logic [15:0] x_i,
  output logic [2:0]  idx_o
);

  localparam logic [15:0] BAR_W = 16'(SCREEN_WIDTH / 8);

  always_comb begin
    idx_o = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x_i >= 16'(k) * BAR_W) idx_o = idx_o + 3'd1;
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator: answers each pixel request one cycle later with
// an RGB565 colour; mode changes and frame counting happen only at pixel (0,0).
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 240,
  parameter int          SPLIT_X       = 160,
  parameter logic [15:0] COLOR_A       = 16'h0000,
  parameter logic [15:0] COLOR_B       = 16'hFFFF,
  parameter int          CHECK_SHIFT   = 4,
  parameter int          GRAD_SHIFT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mode_i,
  input  logic        mode_valid_i,
  input  logic        flush_data_update_i,
  input  logic [15:0] flush_addr_width_i,
  input  logic [15:0] flush_addr_height_i,
  output logic [15:0] flush_data_o,
  output logic        frame_start_o,
  output logic [7:0]  frame_cnt_o,
  output logic [2:0]  mode_active_o
);

  // Request protocol: flush_data_update_i is a one-cycle request with the
  // address valid in the same cycle; the pixel is presented the next cycle and
  // then held. There is no back-pressure.

  localparam logic [15:0] WIDTH_W  = 16'(SCREEN_WIDTH);
  localparam logic [15:0] HEIGHT_W = 16'(SCREEN_HEIGHT);
  localparam logic [15:0] SPLIT_W  = 16'(SPLIT_X);

  logic [15:0] flush_data_q, flush_data_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]  mode_active_q, mode_active_d;
  logic [2:0]  mode_pending_q, mode_pending_d;

  logic        in_range;
  logic        frame_start;
  logic [2:0]  mode_render;
  logic [2:0]  bar_idx;
  logic [2:0]  scroll_idx;
  logic [15:0] grad_x;
  logic [4:0]  grad_g;
  logic        checker_bit;
  logic [15:0] pixel;

  lcd_bar_index #(
    .SCREEN_WIDTH(SCREEN_WIDTH)
  ) u_bar_index (
    .x_i   (flush_addr_width_i),
    .idx_o (bar_idx)
  );

  always_comb begin
    in_range    = (flush_addr_width_i < WIDTH_W) && (flush_addr_height_i < HEIGHT_W);
    frame_start = flush_data_update_i && in_range &&
                  (flush_addr_width_i == 16'd0) && (flush_addr_height_i == 16'd0);

    // A strobe in the frame-start cycle already applies to pixel (0,0).
    mode_pending_d = mode_valid_i ? mode_i : mode_pending_q;
    mode_render    = frame_start ? mode_pending_d : mode_active_q;
    mode_active_d  = mode_render;
    frame_cnt_d    = frame_cnt_q + {7'd0, frame_start};
    frame_start_d  = frame_start;

    scroll_idx  = bar_idx + frame_cnt_d[5:3];
    grad_x      = flush_addr_width_i >> GRAD_SHIFT;
    grad_g      = (grad_x > 16'd31) ? 5'd31 : grad_x[4:0];
    checker_bit = flush_addr_width_i[CHECK_SHIFT] ^ flush_addr_height_i[CHECK_SHIFT];

    case (mode_render)
      MODE_SPLIT:    pixel = (flush_addr_width_i <= SPLIT_W) ? COLOR_A : COLOR_B;
      MODE_BARS:     pixel = bar_color(bar_idx);
      MODE_CHECKER:  pixel = checker_bit ? COLOR_B : COLOR_A;
      MODE_GRADIENT: pixel = grad_pixel(grad_g);
      MODE_SCROLL:   pixel = bar_color(scroll_idx);
      default:       pixel = COLOR_A;
    endcase

    flush_data_d = flush_data_q;
    if (flush_data_update_i) flush_data_d = in_range ? pixel : COLOR_A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_data_q   <= 16'h0000;
      frame_start_q  <= 1'b0;
      frame_cnt_q    <= 8'd0;
      mode_active_q  <= 3'd0;
      mode_pending_q <= 3'd0;
    end else begin
      flush_data_q   <= flush_data_d;
      frame_start_q  <= frame_start_d;
      frame_cnt_q    <= frame_cnt_d;
      mode_active_q  <= mode_active_d;
      mode_pending_q <= mode_pending_d;
    end
  end

  assign flush_data_o  = flush_data_q;
  assign frame_start_o = frame_start_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign mode_active_o = mode_active_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: directed vector table, hand-written frame/reset
// sequences and random requests against an arithmetic reference model.
module tb_lcd_pattern_gen;

  localparam int W     = 320;
  localparam int H     = 240;
  localparam int SPLIT = 160;
  localparam logic [15:0] CA = 16'h0000;
  localparam logic [15:0] CB = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mode_i = 3'd0;
  logic        mode_valid_i = 1'b0;
  logic        flush_data_update_i = 1'b0;
  logic [15:0] flush_addr_width_i = 16'd0;
  logic [15:0] flush_addr_height_i = 16'd0;
  logic [15:0] flush_data_o;
  logic        frame_start_o;
  logic [7:0]  frame_cnt_o;
  logic [2:0]  mode_active_o;

  lcd_pattern_gen dut (
    .clk                 (clk),
    .rst                 (rst),
    .mode_i              (mode_i),
    .mode_valid_i        (mode_valid_i),
    .flush_data_update_i (flush_data_update_i),
    .flush_addr_width_i  (flush_addr_width_i),
    .flush_addr_height_i (flush_addr_height_i),
    .flush_data_o        (flush_data_o),
    .frame_start_o       (frame_start_o),
    .frame_cnt_o         (frame_cnt_o),
    .mode_active_o       (mode_active_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  int          m_pend = 0;
  int          m_act  = 0;
  int          m_fcnt = 0;
  logic [15:0] m_data = 16'h0000;
  logic        m_fs   = 1'b0;

  int palette [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                      16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic logic [15:0] model_pixel(int mode, int x, int y, int fc);
    int bar;
    int g;
    bar = x / (W / 8);
    if (bar > 7) bar = 7;
    case (mode)
      0: return (x <= SPLIT) ? CA : CB;
      2: return 16'(palette[bar]);
      3: return (((x / 16) ^ (y / 16)) % 2 == 1) ? CB : CA;
      4: begin
        g = x / 8;
        if (g > 31) g = 31;
        return 16'((g << 11) | (g << 6) | ((g / 16) << 5) | g);
      end
      5: return 16'(palette[(bar + (fc / 8) % 8) % 8]);
      default: return CA;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, advance the model, then compare all outputs.
  task automatic step(input logic r, input logic u, input int x, input int y,
                      input logic mv, input int m);
    logic fs;
    @(negedge clk);
    rst                 = r;
    flush_data_update_i = u;
    flush_addr_width_i  = 16'(x);
    flush_addr_height_i = 16'(y);
    mode_valid_i        = mv;
    mode_i              = 3'(m);
    if (r) begin
      m_pend = 0; m_act = 0; m_fcnt = 0; m_data = 16'h0000; m_fs = 1'b0;
    end else begin
      if (mv) m_pend = m;
      fs = u && (x == 0) && (y == 0);
      if (fs) begin
        m_fcnt = (m_fcnt + 1) % 256;
        m_act  = m_pend;
      end
      if (u) m_data = (x >= W || y >= H) ? CA : model_pixel(m_act, x, y, m_fcnt);
      m_fs = fs;
    end
    @(posedge clk);
    #1;
    check("flush_data", 32'(flush_data_o), 32'(m_data));
    check("frame_start", 32'(frame_start_o), 32'(m_fs));
    check("frame_cnt", 32'(frame_cnt_o), 32'(m_fcnt));
    check("mode_active", 32'(mode_active_o), 32'(m_act));
  endtask

  task automatic req(input int x, input int y);
    step(1'b0, 1'b1, x, y, 1'b0, 0);
  endtask

  task automatic frame();
    step(1'b0, 1'b1, 0, 0, 1'b0, 0);
  endtask

  task automatic set_mode(input int m);
    step(1'b0, 1'b0, 0, 0, 1'b1, m);
    frame();
  endtask

  typedef struct {
    int          mode;
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  // ---------------- test ----------------
  initial begin
    vecs.push_back('{0, 160, 5, 16'h0000});
    vecs.push_back('{0, 161, 5, 16'hFFFF});
    vecs.push_back('{2, 0, 1, 16'hFFFF});
    vecs.push_back('{2, 39, 1, 16'hFFFF});
    vecs.push_back('{2, 40, 1, 16'hFFE0});
    vecs.push_back('{2, 279, 1, 16'h001F});
    vecs.push_back('{2, 280, 1, 16'h0000});
    vecs.push_back('{2, 319, 1, 16'h0000});
    vecs.push_back('{3, 15, 0, 16'h0000});
    vecs.push_back('{3, 16, 0, 16'hFFFF});
    vecs.push_back('{3, 16, 16, 16'h0000});
    vecs.push_back('{4, 0, 3, 16'h0000});
    vecs.push_back('{4, 8, 3, 16'h0841});
    vecs.push_back('{4, 319, 3, 16'hFFFF});
    vecs.push_back('{1, 50, 50, 16'h0000});
    vecs.push_back('{7, 200, 100, 16'h0000});
    vecs.push_back('{2, 320, 0, 16'h0000});
    vecs.push_back('{2, 0, 240, 16'h0000});

    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 5, 5, 1'b1, 3);
    check("reset_data", 32'(flush_data_o), 32'h0);
    check("reset_mode", 32'(mode_active_o), 32'h0);

    // Mode 0 is active straight out of reset, no frame start needed.
    foreach (vecs[i]) begin
      if (vecs[i].mode != int'(mode_active_o)) set_mode(vecs[i].mode);
      req(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d_pixel", i), 32'(flush_data_o), 32'(vecs[i].exp));
      if (vecs[i].x >= W || vecs[i].y >= H)
        check($sformatf("vec%0d_no_fs", i), 32'(frame_start_o), 32'h0);
    end

    // Held output when no request.
    req(161, 5);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 7, 9, 1'b0, 0);

    // Pending mode does not take effect mid-frame.
    set_mode(2);
    step(1'b0, 1'b1, 100, 50, 1'b1, 3);
    check("pending_mid_frame", 32'(mode_active_o), 32'd2);
    req(200, 60);
    check("pending_mid_frame2", 32'(mode_active_o), 32'd2);
    frame();
    check("pending_applied", 32'(mode_active_o), 32'd3);
    check("pending_fs", 32'(frame_start_o), 32'd1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);
    check("fs_one_cycle", 32'(frame_start_o), 32'd0);

    // Strobe coincident with frame start renders pixel (0,0) in the new mode.
    set_mode(0);
    step(1'b0, 1'b1, 0, 0, 1'b1, 2);
    check("coincident_pixel", 32'(flush_data_o), 32'hFFFF);

    // Scroll mode across frame 7 -> 8 and a full counter wrap.
    set_mode(5);
    while (m_fcnt != 6) frame();
    frame();
    check("scroll_f7_cnt", 32'(frame_cnt_o), 32'd7);
    check("scroll_f7_px", 32'(flush_data_o), 32'hFFFF);
    frame();
    check("scroll_f8_cnt", 32'(frame_cnt_o), 32'd8);
    check("scroll_f8_px", 32'(flush_data_o), 32'hFFE0);
    req(45, 10);
    while (m_fcnt != 255) frame();
    frame();
    check("cnt_wrap", 32'(frame_cnt_o), 32'd0);

    // Reset in the middle of a mode-3 frame.
    set_mode(3);
    req(16, 0);
    step(1'b1, 1'b1, 16, 0, 1'b0, 0);
    check("rst_mid_data", 32'(flush_data_o), 32'h0);
    check("rst_mid_cnt", 32'(frame_cnt_o), 32'h0);
    req(200, 5);
    check("post_rst_mode0", 32'(flush_data_o), 32'hFFFF);
    frame();
    check("post_rst_pend0", 32'(mode_active_o), 32'd0);

    // Random requests and mode strobes.
    for (int n = 0; n < 1500; n++) begin
      int x;
      int y;
      logic u;
      logic mv;
      x  = $urandom_range(0, 335);
      y  = $urandom_range(0, 255);
      if ($urandom_range(0, 15) == 0) begin x = 0; y = 0; end
      u  = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 7) == 0);
      step(1'b0, u, x, y, mv, $urandom_range(0, 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
